// File: rtl/rcv_fifo_if.sv
// Receiver-side and host-side signals of the receive FIFO, grouped as one bundle.
// The slave modport is the FIFO; the master modport is whoever drives it.
interface rcv_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          data_ready;
  logic          overrun_error;
  logic          framing_error;
  logic          data_read;
  logic          rd_en;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          err_clr;
  logic          overrun_flag;
  logic          framing_flag;
  logic [7:0]    framing_count;

  modport slave (
    input  rx_data, data_ready, overrun_error, framing_error, rd_en, err_clr,
    output data_read, dout, empty, full, count, overrun_flag, framing_flag, framing_count
  );

  modport master (
    output rx_data, data_ready, overrun_error, framing_error, rd_en, err_clr,
    input  data_read, dout, empty, full, count, overrun_flag, framing_flag, framing_count
  );
endinterface

// File: rtl/rcv_fifo.sv
// Drains the UART receiver into a show-ahead byte FIFO and tracks receiver errors
// as sticky flags plus a saturating framing-error edge counter.
module rcv_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  rcv_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t        state;
  logic          data_read_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic          empty_c;
  logic          full_c;
  logic          wr_c;
  logic          pop_c;
  logic          fe_q;
  logic          fe_rise_c;
  logic          overrun_q;
  logic          framing_q;
  logic [7:0]    fcount_q;

  assign empty_c   = (count_q == CW'(0));
  assign full_c    = (count_q == CW'(DEPTH));
  assign wr_c      = (state == ACK);
  assign pop_c     = bus.rd_en && !empty_c;
  assign fe_rise_c = bus.framing_error && !fe_q;

  // Drain FSM: the acknowledge is registered on entry to ACK so it is high exactly in ACK.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      data_read_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_ready && !full_c) begin
            state       <= ACK;
            data_read_q <= 1'b1;
          end else begin
            data_read_q <= 1'b0;
          end
        end
        ACK: begin
          state       <= HOLD;
          data_read_q <= 1'b0;
        end
        HOLD: begin
          state       <= IDLE;
          data_read_q <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          data_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; a reset during ACK must not commit the in-flight byte.
  always_ff @(posedge clk) begin
    if (n_rst && wr_c) begin
      mem[wptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_c)  wptr <= wptr + AW'(1);
      if (pop_c) rptr <= rptr + AW'(1);
      case ({wr_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Error tracking: a set condition beats err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fe_q      <= 1'b0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
      fcount_q  <= 8'd0;
    end else begin
      fe_q <= bus.framing_error;
      if (bus.overrun_error)  overrun_q <= 1'b1;
      else if (bus.err_clr)   overrun_q <= 1'b0;
      if (bus.framing_error)  framing_q <= 1'b1;
      else if (bus.err_clr)   framing_q <= 1'b0;
      if (bus.err_clr)
        fcount_q <= fe_rise_c ? 8'd1 : 8'd0;
      else if (fe_rise_c && (fcount_q != 8'hFF))
        fcount_q <= fcount_q + 8'd1;
    end
  end

  assign bus.data_read     = data_read_q;
  assign bus.dout          = empty_c ? 8'h00 : mem[rptr];
  assign bus.empty         = empty_c;
  assign bus.full          = full_c;
  assign bus.count         = count_q;
  assign bus.overrun_flag  = overrun_q;
  assign bus.framing_flag  = framing_q;
  assign bus.framing_count = fcount_q;
endmodule

// File: tb/tb_rcv_fifo.sv
// Self-checking bench for rcv_fifo: a receiver model feeds bytes, a scoreboard
// queue holds the expected read order, host pops compare against it.
module tb_rcv_fifo;
  logic clk = 1'b0;
  logic n_rst;

  rcv_fifo_if #(.DEPTH(8)) bus ();

  rcv_fifo #(.DEPTH(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  logic hold_rdy = 1'b0;
  logic prev_dr = 1'b0;
  logic [7:0] txq[$];
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Receiver model: presents queued bytes, drops data_ready once acknowledged.
  initial begin
    bus.rx_data    = 8'h00;
    bus.data_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.data_read) begin
        check_eq("dr_one_cycle", 32'(prev_dr), 32'd0);
        ack_cnt++;
      end
      if (bus.data_ready) begin
        if (bus.data_read && !hold_rdy) bus.data_ready = 1'b0;
      end else if (txq.size() > 0) begin
        bus.rx_data    = txq.pop_front();
        bus.data_ready = 1'b1;
      end
      prev_dr = bus.data_read;
    end
  end

  task automatic send(input logic [7:0] b);
    txq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((txq.size() > 0 || bus.data_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.data_read && n < 40);
    if (!bus.data_read) check_eq("ack_timeout", 32'd1, 32'd0);
  endtask

  task automatic pop();
    int n = 0;
    logic [7:0] e;
    @(negedge clk);
    while (bus.empty && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check_eq("pop_dout", 32'(bus.dout), 32'(e));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_data_read", 32'(bus.data_read), 32'd0);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_dout", 32'(bus.dout), 32'd0);
    check_eq("rst_oflag", 32'(bus.overrun_flag), 32'd0);
    check_eq("rst_fflag", 32'(bus.framing_flag), 32'd0);
    check_eq("rst_fcount", 32'(bus.framing_count), 32'd0);
  endtask

  initial begin
    int a0;
    n_rst = 1'b0;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
    bus.overrun_error = 1'b0;
    bus.framing_error = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    n_rst = 1'b1;

    // Single byte
    send(8'hA5);
    wait_ack();
    @(negedge clk);
    check_eq("single_dr_low", 32'(bus.data_read), 32'd0);
    check_eq("single_count", 32'(bus.count), 32'd1);
    check_eq("single_empty", 32'(bus.empty), 32'd0);
    check_eq("single_dout", 32'(bus.dout), 32'hA5);
    a0 = ack_cnt;
    repeat (10) @(negedge clk);
    check_eq("single_no_rewrite", 32'(ack_cnt - a0), 32'd0);
    check_eq("single_count2", 32'(bus.count), 32'd1);
    pop();
    check_eq("single_empty_after", 32'(bus.empty), 32'd1);

    // Reset during ACK with three bytes stored
    send(8'h41); send(8'h42); send(8'h43);
    wait_drained();
    check_eq("rst_pre_count", 32'(bus.count), 32'd3);
    hold_rdy = 1'b1;
    send(8'h44);
    wait_ack();
    n_rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h44);
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    n_rst = 1'b1;
    hold_rdy = 1'b0;
    a0 = ack_cnt;
    repeat (12) @(negedge clk);
    check_eq("rst_reack_once", 32'(ack_cnt - a0), 32'd1);
    check_eq("rst_post_count", 32'(bus.count), 32'd1);
    pop();

    // Fill and backpressure
    for (int i = 1; i <= 8; i++) send(8'(i));
    wait_drained();
    check_eq("fill_full", 32'(bus.full), 32'd1);
    check_eq("fill_count", 32'(bus.count), 32'd8);
    send(8'h09);
    a0 = ack_cnt;
    repeat (20) @(negedge clk);
    check_eq("bp_no_ack", 32'(ack_cnt - a0), 32'd0);
    check_eq("bp_ready_held", 32'(bus.data_ready), 32'd1);
    pop();
    check_eq("rel_full_clr", 32'(bus.full), 32'd0);
    check_eq("rel_dr_p1", 32'(bus.data_read), 32'd0);
    @(negedge clk);
    check_eq("rel_dr_p2", 32'(bus.data_read), 32'd1);
    wait_drained();
    check_eq("rel_count", 32'(bus.count), 32'd8);
    repeat (8) pop();
    check_eq("fill_empty", 32'(bus.empty), 32'd1);

    // Simultaneous pop and write at count 3
    send(8'h31); send(8'h32); send(8'h33);
    wait_drained();
    check_eq("sim_pre_count", 32'(bus.count), 32'd3);
    send(8'h34);
    wait_ack();
    check_eq("sim_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check_eq("sim_count", 32'(bus.count), 32'd3);
    repeat (3) pop();
    check_eq("sim_empty", 32'(bus.empty), 32'd1);

    // Wrap-around streaming with a pop every 4th cycle
    for (int i = 0; i < 20; i++) send(8'(8'h10 + i));
    for (int i = 0; i < 20; i++) begin
      repeat (2) @(negedge clk);
      pop();
    end
    check_eq("wrap_empty", 32'(bus.empty), 32'd1);
    check_eq("wrap_count", 32'(bus.count), 32'd0);
    check_eq("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Error flags and framing counter
    check_eq("err_fflag0", 32'(bus.framing_flag), 32'd0);
    repeat (2) begin
      @(negedge clk) bus.framing_error = 1'b1;
      repeat (3) @(negedge clk);
      bus.framing_error = 1'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    check_eq("err_fcount2", 32'(bus.framing_count), 32'd2);
    check_eq("err_fflag1", 32'(bus.framing_flag), 32'd1);
    check_eq("err_oflag0", 32'(bus.overrun_flag), 32'd0);
    bus.err_clr = 1'b1;
    bus.overrun_error = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    bus.overrun_error = 1'b0;
    check_eq("clr_oflag", 32'(bus.overrun_flag), 32'd1);
    check_eq("clr_fflag", 32'(bus.framing_flag), 32'd0);
    check_eq("clr_fcount", 32'(bus.framing_count), 32'd0);
    bus.err_clr = 1'b1;
    bus.framing_error = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    bus.framing_error = 1'b0;
    check_eq("clr_rise_fcount", 32'(bus.framing_count), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      bus.framing_error = 1'b1;
      @(negedge clk);
      bus.framing_error = 1'b0;
      @(negedge clk);
    end
    check_eq("sat_fcount", 32'(bus.framing_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
